data_ram_port_arbiter: RTL and testbench

- Shares port 1 (data port) of the 16x128 two-port RAM between the processor data interface and a host/debug requester (bench loader, debug dump, future DMA).
- The processor has no native stall, so it has fixed priority on the port.
- A host waiting too long raises `proc_stall` to open a slot.
- Sits between `proc` data-RAM pins and `ram_rw_2p_16x128` port 1; port 0 (program fetch) is untouched.

---
 rtl/data_ram_port_arbiter_if.sv | 33 +++
 rtl/data_ram_port_arbiter.sv | 69 ++++++
 tb/tb_data_ram_port_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_port_arbiter_if.sv
// data_ram_port_arbiter_if: processor, host and RAM port-1 signals around the data-port arbiter
interface data_ram_port_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 16
);
    logic          p_read_en;
    logic          p_write_en;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_din;
    logic [DW-1:0] p_dout;
    logic          proc_stall;
    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_ack;
    logic [DW-1:0] h_rdata;
    logic          ram_read_en;
    logic          ram_write_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  p_read_en, p_write_en, p_addr, p_din, h_req, h_we, h_addr, h_wdata, ram_dout,
        output p_dout, proc_stall, h_ack, h_rdata, ram_read_en, ram_write_en, ram_addr, ram_din
    );

    modport master (
        output p_read_en, p_write_en, p_addr, p_din, h_req, h_we, h_addr, h_wdata, ram_dout,
        input  p_dout, proc_stall, h_ack, h_rdata, ram_read_en, ram_write_en, ram_addr, ram_din
    );
endinterface

// File: rtl/data_ram_port_arbiter.sv
// data_ram_port_arbiter: shares RAM port 1 between the stall-less processor (priority) and a host requester
module data_ram_port_arbiter #(
    parameter int AW           = 7,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 8,
    parameter int CW           = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    data_ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARB, RESP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] wait_cnt, wait_cnt_nx;
    logic          stall, stall_nx;
    logic          p_access;
    logic          host_go;

    assign p_access = bus.p_read_en | bus.p_write_en;
    assign host_go  = state == ARB && bus.h_req && !p_access;

    // state, starvation counter and stall flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            stall    <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            stall    <= stall_nx;
        end
    end

    // arbitration: processor always wins, host issues only on a free ARB cycle
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        stall_nx    = stall;
        case (state)
            IDLE: begin
                wait_cnt_nx = '0;
                state_nx    = bus.h_req ? ARB : IDLE;
            end
            ARB: begin
                if (!bus.h_req || !p_access) begin
                    state_nx    = bus.h_req ? RESP : IDLE;
                    wait_cnt_nx = '0;
                    stall_nx    = 1'b0;
                end else begin
                    wait_cnt_nx = wait_cnt + CW'(wait_cnt != '1);
                    stall_nx    = stall | (wait_cnt == CW'(STARVE_LIMIT - 1));
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // port mux; reset forces the RAM command quiet immediately
    assign bus.ram_read_en  = rst_n & (p_access ? bus.p_read_en  : host_go & ~bus.h_we);
    assign bus.ram_write_en = rst_n & (p_access ? bus.p_write_en : host_go &  bus.h_we);
    assign bus.ram_addr     = !rst_n ? '0 : host_go ? bus.h_addr  : bus.p_addr;
    assign bus.ram_din      = !rst_n ? '0 : host_go ? bus.h_wdata : bus.p_din;
    assign bus.p_dout       = bus.ram_dout;
    assign bus.h_rdata      = bus.ram_dout;
    assign bus.h_ack        = state == RESP;
    assign bus.proc_stall   = stall;
endmodule

// File: tb/tb_data_ram_port_arbiter.sv
// tb_data_ram_port_arbiter: directed plan plus random traffic against a transaction-level reference
module tb_data_ram_port_arbiter;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    data_ram_port_arbiter_if #(.AW(7), .DW(16)) bus ();

    data_ram_port_arbiter #(.AW(7), .DW(16), .STARVE_LIMIT(LIMIT), .CW(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(int i);
        return (i == 9) ? 16'h0042 : 16'((i * 311) ^ 42435);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // environment RAM: synchronous read, one cycle latency
    logic [15:0] mem [128];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = init_val(i);
        bus.ram_dout = '0;
        forever begin
            @(posedge clk);
            if (bus.ram_write_en) mem[bus.ram_addr] <= bus.ram_din;
            if (bus.ram_read_en) bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    // reference: host request becomes eligible the cycle after it is seen idle,
    // issues on the first eligible cycle the processor leaves free, acks next cycle;
    // stall reflects the number of consecutive lost eligible cycles
    logic [15:0] ref_mem [128];
    bit          pend, ack_now, hr_read, prd_pend, p_acc, issue;
    int          lost;
    logic [15:0] prd_exp, hr_exp;
    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_read_en", bus.ram_read_en, 0);
                chk("rst_write_en", bus.ram_write_en, 0);
                chk("rst_addr", bus.ram_addr, 0);
                chk("rst_din", bus.ram_din, 0);
                chk("rst_stall", bus.proc_stall, 0);
                chk("rst_ack", bus.h_ack, 0);
                pend = 0; ack_now = 0; lost = 0; prd_pend = 0;
            end else begin
                p_acc = bus.p_read_en | bus.p_write_en;
                issue = pend && bus.h_req && !p_acc;
                chk("stall", bus.proc_stall, lost >= LIMIT);
                chk("ack", bus.h_ack, ack_now);
                if (ack_now && hr_read) chk("h_rdata", bus.h_rdata, hr_exp);
                if (prd_pend) chk("p_dout", bus.p_dout, prd_exp);
                chk("ram_read_en", bus.ram_read_en, p_acc ? bus.p_read_en : issue && !bus.h_we);
                chk("ram_write_en", bus.ram_write_en, p_acc ? bus.p_write_en : issue && bus.h_we);
                if (p_acc || issue) chk("ram_addr", bus.ram_addr, p_acc ? bus.p_addr : bus.h_addr);
                if (p_acc ? bus.p_write_en : issue && bus.h_we)
                    chk("ram_din", bus.ram_din, p_acc ? bus.p_din : bus.h_wdata);
                prd_pend = p_acc && bus.p_read_en;
                if (prd_pend) prd_exp = ref_mem[bus.p_addr];
                if (p_acc && bus.p_write_en) ref_mem[bus.p_addr] = bus.p_din;
                if (issue) begin
                    hr_read = !bus.h_we;
                    hr_exp  = ref_mem[bus.h_addr];
                    if (bus.h_we) ref_mem[bus.h_addr] = bus.h_wdata;
                end
                if (ack_now) ack_now = 0;
                else if (pend && (!bus.h_req || !p_acc)) begin
                    pend = 0; lost = 0; ack_now = issue;
                end else if (pend) lost++;
                else pend = bus.h_req;
            end
        end
    end

    task automatic host_xfer(input logic we, input logic [6:0] a, input logic [15:0] d,
                             output int lat, output logic [15:0] rd);
        tick();
        bus.h_req = 1; bus.h_we = we; bus.h_addr = a; bus.h_wdata = d;
        lat = -1;
        rd  = '0;
        for (int n = 0; n < 40 && lat < 0; n++) begin
            @(negedge clk);
            if (bus.h_ack) begin lat = n; rd = bus.h_rdata; end
        end
        tick();
        bus.h_req = 0;
    endtask

    int          lat, first_stall, ack_cyc, acks, busy, stall11;
    logic [15:0] rd;
    logic        st, ak, pa, pw;

    initial begin
        bus.p_read_en = 0; bus.p_write_en = 0; bus.p_addr = '0; bus.p_din = '0;
        bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        host_xfer(1, 7'd5, 16'hBEEF, lat, rd);
        chk("t1_latency", lat, 2);
        chk("t1_mem5", mem[5], 16'hBEEF);
        chk("t1_ref5", ref_mem[5], 16'hBEEF);

        host_xfer(0, 7'd5, 16'h0000, lat, rd);
        chk("t2_latency", lat, 2);
        chk("t2_rdata", rd, 16'hBEEF);

        first_stall = -1; ack_cyc = -1; st = 0; ak = 0; stall11 = -1;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (k == 0) begin bus.h_req = 1; bus.h_we = 0; bus.h_addr = 7'd9; end
            else if (ak) bus.h_req = 0;
            bus.p_read_en = (k < 20) && !st;
            bus.p_addr = 7'(k + 20);
            @(negedge clk);
            st = bus.proc_stall; ak = bus.h_ack;
            if (st && first_stall < 0) first_stall = k;
            if (ak) begin ack_cyc = k; rd = bus.h_rdata; end
            if (k == 11) stall11 = int'(st);
        end
        chk("t3_stall_rise", first_stall, 9);
        chk("t3_ack_cycle", ack_cyc, 11);
        chk("t3_rdata", rd, 16'h0042);
        chk("t3_stall_fall", stall11, 0);

        acks = 0;
        tick();
        bus.p_write_en = 1; bus.p_addr = 7'd3; bus.p_din = 16'h1111;
        bus.h_req = 1; bus.h_we = 1; bus.h_addr = 7'd3; bus.h_wdata = 16'h2222;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ak = bus.h_ack;
            acks += int'(ak);
            tick();
            bus.p_write_en = 0;
            if (ak) bus.h_req = 0;
        end
        chk("t4_acks", acks, 1);
        chk("t4_mem3", mem[3], 16'h2222);

        acks = 0;
        bus.h_req = 1; bus.h_we = 1; bus.h_addr = 7'd7; bus.h_wdata = 16'h7777;
        bus.p_read_en = 1; bus.p_addr = 7'd1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            acks += int'(bus.h_ack);
            tick();
            if (k == 3) bus.h_req = 0;
        end
        bus.p_read_en = 0;
        chk("t5_acks", acks, 0);
        chk("t5_stall", bus.proc_stall, 0);
        chk("t5_mem7", mem[7], init_val(7));

        bus.h_req = 1; bus.h_we = 0; bus.h_addr = 7'd9; bus.p_read_en = 1;
        repeat (12) @(negedge clk);
        chk("t6_stall_before", bus.proc_stall, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_async_stall", bus.proc_stall, 0);
        chk("t6_async_read_en", bus.ram_read_en, 0);
        chk("t6_async_ack", bus.h_ack, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        bus.p_read_en = 0;
        lat = -1;
        for (int n = 0; n < 20 && lat < 0; n++) begin
            @(negedge clk);
            if (bus.h_ack) begin lat = n; rd = bus.h_rdata; end
        end
        chk("t6_idle_latency", lat, 2);
        chk("t6_rdata", rd, 16'h0042);
        tick();
        bus.h_req = 0;

        busy = 50; st = 0; ak = 0;
        for (int c = 0; c < 800; c++) begin
            if (c % 60 == 0) busy = ($urandom_range(0, 1) != 0) ? 95 : 35;
            tick();
            if (bus.h_req && ak) bus.h_req = 0;
            else if (bus.h_req && $urandom_range(0, 59) == 0) bus.h_req = 0;
            else if (!bus.h_req && $urandom_range(0, 2) == 0) begin
                bus.h_req = 1;
                bus.h_we = 1'($urandom_range(0, 1));
                bus.h_addr = 7'($urandom_range(0, 15));
                bus.h_wdata = 16'($urandom);
            end
            pa = st ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) < busy);
            pw = 1'($urandom_range(0, 1));
            bus.p_read_en = pa & !pw;
            bus.p_write_en = pa & pw;
            bus.p_addr = 7'($urandom_range(0, 15));
            bus.p_din = 16'($urandom);
            @(negedge clk);
            st = bus.proc_stall; ak = bus.h_ack;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
